// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: 1024x768@60 video timing generator and raster-order framebuffer reader.
// Integer upscaling walks the framebuffer incrementally (no multiplier); sync/blank are
// delayed to line up with the 2-cycle BRAM read latency plus one output register.
// Optional feature: define SCANOUT_BORDER_EN to paint in-active-area pixels that fall
// outside the framebuffer region with BORDER_COLOR instead of 0.

`ifndef COLOR_BITS
`define COLOR_BITS 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 16
`endif

module framebuffer_scanout #(
  parameter int unsigned      WIDTH        = `COLOR_BITS,
  parameter int unsigned      ADDR_LEN     = `ADDR_BITS,
  parameter int unsigned      FB_WIDTH     = 256,
  parameter int unsigned      FB_HEIGHT    = 192,
  parameter int unsigned      SCALE_SHIFT  = 2,
  parameter int unsigned      H_ACTIVE     = 1024,
  parameter int unsigned      H_FP         = 24,
  parameter int unsigned      H_SYNC       = 136,
  parameter int unsigned      H_BP         = 160,
  parameter int unsigned      V_ACTIVE     = 768,
  parameter int unsigned      V_FP         = 3,
  parameter int unsigned      V_SYNC       = 6,
  parameter int unsigned      V_BP         = 29,
  parameter logic [WIDTH-1:0] BORDER_COLOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_LEN-1:0] read_addr,
  input  logic [WIDTH-1:0]    read_data,
  output logic [WIDTH-1:0]    pixel_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                blank_out,
  output logic                frame_sync
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);
  localparam int unsigned SW     = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;

  // Framebuffer region on screen, clipped to the active area.
  localparam int unsigned RegionW = ((FB_WIDTH << SCALE_SHIFT) < H_ACTIVE) ?
                                    (FB_WIDTH << SCALE_SHIFT) : H_ACTIVE;
  localparam int unsigned RegionH = ((FB_HEIGHT << SCALE_SHIFT) < V_ACTIVE) ?
                                    (FB_HEIGHT << SCALE_SHIFT) : V_ACTIVE;

  localparam logic [HW-1:0] HLast    = HW'(HTotal - 1);
  localparam logic [HW-1:0] HActive  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HSyncBeg = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HSyncEnd = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] HRegEnd  = HW'(RegionW);
  localparam logic [HW-1:0] HColLast = HW'(RegionW - 1);

  localparam logic [VW-1:0] VLast    = VW'(VTotal - 1);
  localparam logic [VW-1:0] VActive  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VSyncBeg = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VSyncEnd = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] VRegEnd  = VW'(RegionH);
  localparam logic [VW-1:0] VRowLast = VW'(RegionH - 1);

  localparam logic [SW-1:0]       SubMax  = SW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_LEN-1:0] RowStep = ADDR_LEN'(FB_WIDTH);

`ifdef SCANOUT_BORDER_EN
  localparam bit BorderEn = 1'b1;
`else
  localparam bit BorderEn = 1'b0;
`endif
  localparam logic [WIDTH-1:0] BorderPix = BorderEn ? BORDER_COLOR : '0;

  // Refuse to elaborate when the framebuffer cannot be addressed without wrapping.
  if (64'(FB_WIDTH) * 64'(FB_HEIGHT) > (64'd1 << ADDR_LEN)) begin : gen_addr_check
    $error("framebuffer_scanout: FB_WIDTH*FB_HEIGHT exceeds 2^ADDR_LEN");
  end

  // Stage 0: raster counters and incremental address walkers.
  logic [HW-1:0]       hcount_q, hcount_d;
  logic [VW-1:0]       vcount_q, vcount_d;
  logic [ADDR_LEN-1:0] col_q, col_d;
  logic [SW-1:0]       col_sub_q, col_sub_d;
  logic [ADDR_LEN-1:0] row_base_q, row_base_d;
  logic [SW-1:0]       row_sub_q, row_sub_d;
  logic [ADDR_LEN-1:0] read_addr_q, read_addr_d;
  logic                frame_sync_q, frame_sync_d;
  logic                next_in_region;

  // Stage 0 decode (combinational from the current counters).
  logic s0_blank, s0_hsync, s0_vsync, s0_in_region;

  // Delay stages 1 and 2, then the output registers.
  logic             s1_blank_q, s1_hsync_q, s1_vsync_q, s1_in_region_q;
  logic             s2_blank_q, s2_hsync_q, s2_vsync_q, s2_in_region_q;
  logic [WIDTH-1:0] pixel_q, pixel_d;
  logic             hsync_q, vsync_q, blank_q;

  // Next position of the raster and of the framebuffer walk.
  always_comb begin
    hcount_d   = hcount_q;
    vcount_d   = vcount_q;
    col_d      = col_q;
    col_sub_d  = col_sub_q;
    row_base_d = row_base_q;
    row_sub_d  = row_sub_q;
    if (hcount_q == HLast) begin
      hcount_d  = '0;
      col_d     = '0;
      col_sub_d = '0;
      if (vcount_q == VLast) begin
        vcount_d   = '0;
        row_base_d = '0;
        row_sub_d  = '0;
      end else begin
        vcount_d = vcount_q + 1'b1;
        // Row walker stops at the last region row so row_base never leaves the buffer.
        if (vcount_q < VRowLast) begin
          if (row_sub_q == SubMax) begin
            row_sub_d  = '0;
            row_base_d = row_base_q + RowStep;
          end else begin
            row_sub_d = row_sub_q + 1'b1;
          end
        end
      end
    end else begin
      hcount_d = hcount_q + 1'b1;
      if (hcount_q < HColLast) begin
        if (col_sub_q == SubMax) begin
          col_sub_d = '0;
          col_d     = col_q + 1'b1;
        end else begin
          col_sub_d = col_sub_q + 1'b1;
        end
      end
    end
  end

  // Address and frame pulse are registered from the next position so they line up with it.
  always_comb begin
    next_in_region = (hcount_d < HRegEnd) && (vcount_d < VRegEnd);
    read_addr_d    = next_in_region ? (row_base_d + col_d) : '0;
    frame_sync_d   = (hcount_d == '0) && (vcount_d == VActive);
  end

  // Stage 0 sync, blank and region decode.
  always_comb begin
    s0_in_region = (hcount_q < HRegEnd) && (vcount_q < VRegEnd);
    s0_blank     = (hcount_q >= HActive) || (vcount_q >= VActive);
    s0_hsync     = !((hcount_q >= HSyncBeg) && (hcount_q < HSyncEnd));
    s0_vsync     = !((vcount_q >= VSyncBeg) && (vcount_q < VSyncEnd));
  end

  // Output pixel selection at the stage where BRAM data arrives.
  always_comb begin
    pixel_d = '0;
    if (!s2_blank_q) begin
      pixel_d = s2_in_region_q ? read_data : BorderPix;
    end
  end

  // Counter, walker, address and frame-pulse state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q     <= '0;
      vcount_q     <= '0;
      col_q        <= '0;
      col_sub_q    <= '0;
      row_base_q   <= '0;
      row_sub_q    <= '0;
      read_addr_q  <= '0;
      frame_sync_q <= 1'b0;
    end else begin
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      col_q        <= col_d;
      col_sub_q    <= col_sub_d;
      row_base_q   <= row_base_d;
      row_sub_q    <= row_sub_d;
      read_addr_q  <= read_addr_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  // Three-stage delay of sync/blank/region to match BRAM latency plus output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_blank_q     <= 1'b1;
      s1_hsync_q     <= 1'b1;
      s1_vsync_q     <= 1'b1;
      s1_in_region_q <= 1'b0;
      s2_blank_q     <= 1'b1;
      s2_hsync_q     <= 1'b1;
      s2_vsync_q     <= 1'b1;
      s2_in_region_q <= 1'b0;
      pixel_q        <= '0;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      blank_q        <= 1'b1;
    end else begin
      s1_blank_q     <= s0_blank;
      s1_hsync_q     <= s0_hsync;
      s1_vsync_q     <= s0_vsync;
      s1_in_region_q <= s0_in_region;
      s2_blank_q     <= s1_blank_q;
      s2_hsync_q     <= s1_hsync_q;
      s2_vsync_q     <= s1_vsync_q;
      s2_in_region_q <= s1_in_region_q;
      pixel_q        <= pixel_d;
      hsync_q        <= s2_hsync_q;
      vsync_q        <= s2_vsync_q;
      blank_q        <= s2_blank_q;
    end
  end

  assign read_addr  = read_addr_q;
  assign frame_sync = frame_sync_q;
  assign pixel_out  = pixel_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign blank_out  = blank_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout. A reduced-timing instance is checked every cycle against a
// position-based reference model through a scoreboard; a default-parameter instance is
// spot-checked on its first lines (full default frames are too long to simulate here).

module tb_framebuffer_scanout;

  // Reduced configuration: 64x32 region inside an 80x40 active area.
  localparam int FBW = 16, FBH = 8, SCL = 4;
  localparam int HA = 80, HFP = 4, HS = 8, HBP = 8, HT = HA + HFP + HS + HBP;
  localparam int VA = 40, VFP = 2, VS = 3, VBP = 5, VT = VA + VFP + VS + VBP;
  localparam logic [7:0] BORDER = 8'd5;
`ifdef SCANOUT_BORDER_EN
  localparam logic [7:0] ExpBorder = BORDER;
`else
  localparam logic [7:0] ExpBorder = 8'd0;
`endif

  typedef struct packed {
    logic [7:0] pix;
    logic       hs;
    logic       vs;
    logic       bl;
  } vid_t;
  typedef struct packed {
    logic [7:0] addr;
    logic       fs;
  } adr_t;

  localparam vid_t RstVid = '{pix: 8'd0, hs: 1'b1, vs: 1'b1, bl: 1'b1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr1, rdata1, pix1, p1;
  logic       hs1, vs1, bl1, fs1;
  logic [15:0] addr2;
  logic [7:0]  rdata2, pix2, p2;
  logic        hs2, vs2, bl2, fs2;

  logic [7:0] mem1 [256];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t = 0;
  bit   in_rst = 1'b1;
  int   last_fs = -1;
  vid_t exp_vid [int];
  adr_t exp_a [$];

  always #5 clk = ~clk;

  framebuffer_scanout #(
    .WIDTH(8), .ADDR_LEN(8), .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .SCALE_SHIFT(2),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .BORDER_COLOR(BORDER)
  ) u_small (
    .clk(clk), .rst(rst), .read_addr(addr1), .read_data(rdata1), .pixel_out(pix1),
    .hsync_out(hs1), .vsync_out(vs1), .blank_out(bl1), .frame_sync(fs1)
  );

  framebuffer_scanout #(
    .WIDTH(8), .ADDR_LEN(16)
  ) u_dflt (
    .clk(clk), .rst(rst), .read_addr(addr2), .read_data(rdata2), .pixel_out(pix2),
    .hsync_out(hs2), .vsync_out(vs2), .blank_out(bl2), .frame_sync(fs2)
  );

  // BRAM models with 2-cycle read latency.
  always @(posedge clk) begin
    p1     <= mem1[addr1];
    rdata1 <= p1;
    p2     <= addr2[7:0];
    rdata2 <= p2;
  end

  function automatic bit in_fb(int h, int v);
    return (h < HA) && (v < VA) && (h < FBW * SCL) && (v < FBH * SCL);
  endfunction

  function automatic int addr_of(int h, int v);
    return in_fb(h, v) ? (v / SCL) * FBW + (h / SCL) : 0;
  endfunction

  function automatic vid_t expect_vid(int h, int v);
    vid_t r;
    r.bl = (h >= HA) || (v >= VA);
    r.hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
    r.vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
    if (r.bl) r.pix = 8'd0;
    else if (in_fb(h, v)) r.pix = mem1[addr_of(h, v)];
    else r.pix = ExpBorder;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d t=%0d got=%0h expected=%0h", name, cyc, t, act, exp);
    end
  endtask

  // Reference model: derives the raster position from cycles since reset and schedules
  // the expected outputs; a reset cycle holds position (0,0) and blanks the pipeline.
  initial begin
    forever begin
      int h, v;
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        in_rst = 1'b1;
        t = 0;
        exp_vid.delete();
        exp_a.delete();
        exp_a.push_back('{addr: 8'd0, fs: 1'b0});
        exp_vid[cyc]     = RstVid;
        exp_vid[cyc + 1] = RstVid;
        exp_vid[cyc + 2] = RstVid;
        exp_vid[cyc + 3] = expect_vid(0, 0);
      end else begin
        in_rst = 1'b0;
        t++;
        h = t % HT;
        v = (t / HT) % VT;
        exp_a.push_back('{addr: 8'(addr_of(h, v)), fs: (h == 0) && (v == VA)});
        exp_vid[cyc + 3] = expect_vid(h, v);
      end
    end
  end

  // Monitor: pops scheduled expectations and compares against the DUT outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (exp_a.size() == 0) begin
          chk("addr_missing", 32'd0, 32'd1);
        end else begin
          adr_t e;
          e = exp_a.pop_front();
          chk("addr_fs", 32'({addr1, fs1}), 32'(e));
        end
        if (!exp_vid.exists(cyc)) begin
          chk("vid_missing", 32'd0, 32'd1);
        end else begin
          chk("video", 32'({pix1, hs1, vs1, bl1}), 32'(exp_vid[cyc]));
          exp_vid.delete(cyc);
        end
        if (in_rst) begin
          last_fs = -1;
        end else begin
          if (fs1) begin
            if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'(HT * VT));
            last_fs = cyc;
          end
          // Default-parameter instance: line 0 addressing, alignment and line 4 start.
          if (t < 1344) chk("dflt_line0_addr", 32'(addr2), 32'((t < 1024) ? t / 4 : 0));
          if (t == 5376) chk("dflt_line4_addr", 32'(addr2), 32'd256);
          if (t >= 3 && t < 1347) begin
            int p;
            p = t - 3;
            chk("dflt_pix", 32'(pix2), 32'((p < 1024) ? (p / 4) % 256 : 0));
            chk("dflt_blank", 32'(bl2), 32'(p >= 1024));
            chk("dflt_hsync", 32'(hs2), 32'(!((p >= 1048) && (p < 1184))));
          end
          if (t < 5376) chk("dflt_vsync_fs", 32'({vs2, fs2}), 32'd2);
        end
      end
    end
  end

  // Stimulus: random BRAM contents, reset release, random mid-frame reset, run on.
  initial begin
    int rst_at;
    int rst_len;
    for (int i = 0; i < 256; i++) mem1[i] = 8'($urandom);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    rst_at  = $urandom_range(8999, 6000);
    rst_len = $urandom_range(4, 1);
    repeat (rst_at) @(negedge clk);
    rst = 1'b1;
    repeat (rst_len) @(negedge clk);
    rst = 1'b0;
    repeat (9600) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
# framebuffer_scanout

Display-side reader for the double-buffered framebuffer. Generates 1024x768@60 video timing from the pixel clock and walks the framebuffer in raster order with integer upscaling. Drives `read_addr` into the buffer manager and realigns sync and blank with the 2-cycle BRAM read latency. Emits a start-of-vblank pulse so the renderer can assert `swap_buffers` tear-free.

## Interface
Parameters:
- `WIDTH`, `` `COLOR_BITS ``: pixel word width.
- `ADDR_LEN`, `` `ADDR_BITS ``: framebuffer address width.
- `FB_WIDTH`, 256: framebuffer columns.
- `FB_HEIGHT`, 192: framebuffer rows.
- `SCALE_SHIFT`, 2: each framebuffer pixel is 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels.
- `H_ACTIVE/H_FP/H_SYNC/H_BP`, 1024/24/136/160: horizontal timing; total 1344.
- `V_ACTIVE/V_FP/V_SYNC/V_BP`, 768/3/6/29: vertical timing; total 806.
- `BORDER_COLOR`, 0: colour outside the framebuffer region (only with the macro below).

Ports:
- `clk`, in, 1: pixel clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `read_addr`, out, ADDR_LEN: framebuffer read address.
- `read_data`, in, WIDTH: BRAM data; valid 2 cycles after `read_addr`.
- `pixel_out`, out, WIDTH: pixel colour; 0 when blanked.
- `hsync_out`, out, 1: active-low horizontal sync.
- `vsync_out`, out, 1: active-low vertical sync.
- `blank_out`, out, 1: 1 outside the active area.
- `frame_sync`, out, 1: one-cycle pulse at start of vblank.

## Operation
- Counters `hcount` (0..1343) and `vcount` (0..805).
  - `hcount` wraps to 0 after 1343 and increments `vcount`.
  - `vcount` wraps to 0 after 805.
- In-region when `hcount < FB_WIDTH<<SCALE_SHIFT` and `vcount < FB_HEIGHT<<SCALE_SHIFT`, both inside the active area.
- Address generation is incremental; no multiplier.
  - `col_sub` counts 0..2^S-1 within a line and advances `col` on wrap.
  - `row_sub` counts 0..2^S-1 per active line; on wrap `row_base += FB_WIDTH`.
  - `col`, `col_sub` clear at `hcount==0`.
  - `row_base`, `row_sub` clear at `vcount==0, hcount==0`.
- `read_addr` (registered) = `row_base + col` when in-region, else 0.
- Sync/blank decode:
  - hsync low for `H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC`.
  - vsync low for `V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC`.
  - Blank = `hcount>=H_ACTIVE || vcount>=V_ACTIVE`.
- `frame_sync` = 1 for exactly the cycle where `hcount==0 && vcount==V_ACTIVE`, undelayed.
- Address arithmetic is ADDR_LEN wide, with no wrap for legal parameters. Require `FB_WIDTH*FB_HEIGHT <= 2^ADDR_LEN`.

## Timing
- Stage 0 (cycle n): counters, `read_addr`, decoded syncs, blank and in-region.
- Stage 0 is delayed through 3 register stages. Stage 2 meets `read_data` for the address presented in stage 0. The stage-3 output registers drive the `*_out` ports.
- Pixel at (h,v) appears on `pixel_out` 3 cycles after the counters equal (h,v). `hsync_out`, `vsync_out` and `blank_out` carry the same 3-cycle delay, so relative alignment is exact.
- `pixel_out` = `read_data` when in-region and not blank; 0 when blank.
- Reset values, held while `rst` is high:
  - `hcount = vcount = 0`; all address counters 0; `read_addr = 0`.
  - `pixel_out = 0`, `hsync_out = vsync_out = 1`, `blank_out = 1`, `frame_sync = 0`.
  - All delay-stage contents are cleared.
- First real pixel (0,0) appears 3 cycles after the first cycle with `rst` low.
- Reset asserted mid-frame aborts immediately. The next frame restarts at (0,0) with no partial pulses.
- A swap issued on `frame_sync` completes in the manager within 3 cycles, well inside vblank (38 lines).

## Configuration
- Macro `SCANOUT_BORDER_EN`.
  - Defined: in-active-area, out-of-region pixels output `BORDER_COLOR`.
  - Undefined: those pixels output 0.
  - Timing and addressing are identical either way.

## Test plan
- Reset release, default parameters:
  - `read_addr` sequence on line 0 is 0,0,0,0,1,1,1,1,…,255 (each repeated 4 times) for `hcount` 0..1023, then 0 during blank.
  - `pixel_out` tracks the BRAM model with 3-cycle delay.
- Line 4 start: `read_addr == 256`. Line 767 last active pixel: `read_addr == 49151`.
- Sync widths over 2 frames:
  - hsync low for 136 cycles per 1344-cycle line.
  - vsync low for exactly 6 lines.
  - `frame_sync` pulses once per 1,083,264 cycles at `vcount==768`.
- Alignment: BRAM model returns `data = addr[WIDTH-1:0]`.
  - `pixel_out` equals the expected value at every active (h,v).
  - `blank_out` rises exactly 3 cycles after `hcount` hits 1024.
- Border, with `SCANOUT_BORDER_EN`, `FB_WIDTH=200`, `BORDER_COLOR=5`:
  - `pixel_out == 5` for h in 800..1023.
  - `pixel_out == 0` for h >= 1024.
  - Without the macro, `pixel_out == 0` for h in 800..1023.
- Reset at (500,300): outputs return to reset values next cycle, and (0,0) data appears 3 cycles after release.
